// File: rtl/vga_capture_if.sv
// VGA pixel/sync bundle: active-low syncs plus RGB, driven by a timing source
// and sampled by the capture block.
interface vga_capture_if #(
  parameter int DATA_W = 24
) ();
  logic              hsync;
  logic              vsync;
  logic [DATA_W-1:0] rgb;

  modport master (output hsync, vsync, rgb);
  modport slave  (input  hsync, vsync, rgb);
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates from hsync/vsync, qualifies
// active-area pixels and verifies line/frame timing before declaring lock.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter int V_TOTAL  = 525,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_capture_if.slave      vin,
  output logic              pix_valid,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err
);

  localparam logic [10:0] HB  = 11'(H_BP);
  localparam logic [10:0] HE  = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] HT1 = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VB  = 10'(V_BP);
  localparam logic [9:0]  VE  = 10'(V_BP + V_ACTIVE);
  localparam logic [10:0] VT  = 11'(V_TOTAL);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic [DATA_W-1:0] rgb_q;
  logic [10:0]       h_pos_q, h_pos;
  logic [9:0]        v_pos_q, v_pos;
  logic [9:0]        fcnt_q, fcnt_d;
  logic [10:0]       line_cnt;
  logic              hrise, vrise, active;
  logic              line_err, frame_bad;
  logic              line_ref_q, line_ref_d;
  logic              acq_bad_q, acq_bad_d;
  logic              err_d;

  function automatic logic [10:0] sat_inc11(input logic [10:0] a);
    return (&a) ? a : a + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] a);
    return (&a) ? a : a + 10'd1;
  endfunction

  // Stage 1: sample the raw syncs and pixel data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      hs_d  <= 1'b1;
      vs_q  <= 1'b1;
      vs_d  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= vin.hsync;
      hs_d  <= hs_q;
      vs_q  <= vin.vsync;
      vs_d  <= vs_q;
      rgb_q <= vin.rgb;
    end
  end

  assign hrise = hs_q & ~hs_d;
  assign vrise = vs_q & ~vs_d;

  // Position of the stage-1 sample; the hrise sample itself is column 0.
  assign h_pos  = hrise ? '0 : sat_inc11(h_pos_q);
  assign v_pos  = vrise ? '0 : (hrise ? sat_inc10(v_pos_q) : v_pos_q);
  assign fcnt_d = vrise ? '0 : (hrise ? sat_inc10(fcnt_q) : fcnt_q);

  // An hrise landing on the vrise cycle still belongs to the frame just ended.
  assign line_cnt  = {1'b0, fcnt_q} + {10'd0, hrise};
  assign frame_bad = (line_cnt != VT);
  assign line_err  = hrise & line_ref_q & (h_pos_q != HT1);

  assign active = (h_pos >= HB) && (h_pos < HE) && (v_pos >= VB) && (v_pos < VE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos_q <= '0;
      v_pos_q <= '0;
      fcnt_q  <= '0;
    end else begin
      h_pos_q <= h_pos;
      v_pos_q <= v_pos;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_ref_d = line_ref_q;
    acq_bad_d  = acq_bad_q;
    err_d      = 1'b0;
    case (state_q)
      SEARCH: begin
        line_ref_d = 1'b0;
        acq_bad_d  = 1'b0;
        if (vrise) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (hrise) line_ref_d = 1'b1;
        if (vrise) begin
          if (!acq_bad_q && !line_err && !frame_bad) state_d = LOCKED;
          acq_bad_d = 1'b0;
        end else if (line_err) begin
          acq_bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (hrise) line_ref_d = 1'b1;
        if (line_err || (vrise && frame_bad)) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      line_ref_q <= 1'b0;
      acq_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_ref_q <= line_ref_d;
      acq_bad_q  <= acq_bad_d;
    end
  end

  // Stage 2: registered pixel and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid   <= active && (state_q == LOCKED);
      frame_start <= active && (state_q == LOCKED) && (h_pos == HB) && (v_pos == VB);
      if (active) begin
        pix_x    <= 10'(h_pos - HB);
        pix_y    <= v_pos - VB;
        pix_data <= rgb_q;
      end
      locked   <= (state_d == LOCKED);
      sync_err <= err_d;
    end
  end

endmodule
